ifu_axi_m: RTL and testbench

Instruction-fetch unit with an AXI-lite read master port. It sits directly upstream of the AXI-lite memory slave. It holds the PC, issues one 32-bit-address read per instruction, and selects the 32-bit instruction from the 64-bit read beat. It presents the instruction to decode through a valid/ready handshake and accepts PC redirects from the execute stage. Only one read is outstanding at a time.

---
 rtl/ifu_axi_m.sv | 181 ++++++++++++++++++
 tb/tb_ifu_axi_m.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu_axi_m.sv
// ---------------------------------------------------------------------------
// ifu_axi_m : instruction-fetch unit with an AXI-lite read master.
//
// Holds the fetch PC, issues one 32-bit-address read per instruction (only
// one outstanding), selects the 32-bit instruction from the 64-bit beat and
// hands it to decode over a valid/ready handshake. Accepts PC redirects from
// execute at any time.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   redirect_valid/pc single-cycle PC redirect (pc[1:0] ignored)
//   inst_valid/ready  decode handshake
//   inst, inst_pc     fetched instruction and its PC
//   inst_err          response for this instruction was not OKAY
//   fetch_cnt         instructions accepted by decode
//   araddr/arvalid/arready          AXI-lite read address channel
//   rdata/rresp/rvalid/rready       AXI-lite read data channel
// ---------------------------------------------------------------------------
module ifu_axi_m #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [63:0] inst_pc,
   output logic        inst_err,
   output logic [63:0] fetch_cnt,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [63:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready
);

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;
   localparam int unsigned AW   = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AR   = 2'd1,
      S_R    = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t            state_q,     state_d;
   logic [XLEN-1:0]   pc_q,        pc_d;
   logic              kill_q,      kill_d;
   logic              redir_q,     redir_d;
   logic [XLEN-1:0]   redir_pc_q,  redir_pc_d;
   logic [ILEN-1:0]   inst_q,      inst_d;
   logic [XLEN-1:0]   inst_pc_q,   inst_pc_d;
   logic              inst_err_q,  inst_err_d;
   logic [XLEN-1:0]   fetch_cnt_q, fetch_cnt_d;

   // Redirect target with the low two bits forced to zero.
   logic [XLEN-1:0]   redirect_pc_al;
   assign redirect_pc_al = redirect_pc & ~XLEN'(3);

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         kill_q      <= 1'b0;
         redir_q     <= 1'b0;
         redir_pc_q  <= '0;
         inst_q      <= '0;
         inst_pc_q   <= '0;
         inst_err_q  <= 1'b0;
         fetch_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         kill_q      <= kill_d;
         redir_q     <= redir_d;
         redir_pc_q  <= redir_pc_d;
         inst_q      <= inst_d;
         inst_pc_q   <= inst_pc_d;
         inst_err_q  <= inst_err_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      kill_d      = kill_q;
      redir_d     = redir_q;
      redir_pc_d  = redir_pc_q;
      inst_d      = inst_q;
      inst_pc_d   = inst_pc_q;
      inst_err_d  = inst_err_q;
      fetch_cnt_d = fetch_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            state_d = S_AR;
            if (redirect_valid) begin
               redir_d    = 1'b1;
               redir_pc_d = redirect_pc_al;
               kill_d     = 1'b1;
            end
         end

         // The request cannot be withdrawn, so a redirect here only marks
         // the coming response as stale.
         S_AR: begin
            if (redirect_valid) begin
               redir_d    = 1'b1;
               redir_pc_d = redirect_pc_al;
               kill_d     = 1'b1;
            end
            if (arready) begin
               state_d = S_R;
            end
         end

         S_R: begin
            if (rvalid) begin
               if (kill_q || redirect_valid) begin
                  // Drop the beat; a redirect in this cycle beats a pending one.
                  kill_d  = 1'b0;
                  redir_d = 1'b0;
                  if (redirect_valid) begin
                     pc_d = redirect_pc_al;
                  end else if (redir_q) begin
                     pc_d = redir_pc_q;
                  end
                  state_d = S_AR;
               end else begin
                  inst_d     = pc_q[2] ? rdata[63:32] : rdata[31:0];
                  inst_pc_d  = pc_q;
                  inst_err_d = (rresp != 2'b00);
                  state_d    = S_OUT;
               end
            end else if (redirect_valid) begin
               redir_d    = 1'b1;
               redir_pc_d = redirect_pc_al;
               kill_d     = 1'b1;
            end
         end

         S_OUT: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc_al;
               state_d = S_AR;
               if (inst_ready) begin
                  fetch_cnt_d = fetch_cnt_q + XLEN'(1);
               end
            end else if (inst_ready) begin
               pc_d        = pc_q + XLEN'(4);
               fetch_cnt_d = fetch_cnt_q + XLEN'(1);
               state_d     = S_AR;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Bus and handshake outputs decode straight from registered state.
   assign arvalid    = (state_q == S_AR);
   assign rready     = (state_q == S_R);
   assign inst_valid = (state_q == S_OUT);
   assign araddr     = pc_q[AW-1:0];
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_err   = inst_err_q;
   assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_ifu_axi_m.sv
// ---------------------------------------------------------------------------
// tb_ifu_axi_m : directed self-checking bench for ifu_axi_m.
// ---------------------------------------------------------------------------
module tb_ifu_axi_m;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        inst_err;
   logic [63:0] fetch_cnt;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   int n_checks = 0;
   int n_fail   = 0;

   ifu_axi_m dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_err       (inst_err),
      .fetch_cnt      (fetch_cnt),
      .araddr         (araddr),
      .arvalid        (arvalid),
      .arready        (arready),
      .rdata          (rdata),
      .rresp          (rresp),
      .rvalid         (rvalid),
      .rready         (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_arvalid(input string tag);
      int n = 0;
      while (arvalid !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      check(tag, 64'(arvalid), 64'd1);
   endtask

   // Issue a read, answer it with one beat and check the captured instruction.
   task automatic fetch(input string tag, input logic [63:0] exp_addr, input logic [63:0] beat,
                        input logic [1:0] resp, input logic [31:0] exp_inst,
                        input logic [63:0] exp_pc, input logic exp_err);
      wait_arvalid({tag, "_arvalid"});
      check({tag, "_araddr"}, 64'(araddr), exp_addr);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      check({tag, "_rready"}, 64'(rready), 64'd1);
      rvalid = 1'b1;
      rdata  = beat;
      rresp  = resp;
      tick();
      rvalid = 1'b0;
      rresp  = 2'b00;
      check({tag, "_ivalid"}, 64'(inst_valid), 64'd1);
      check({tag, "_inst"},   64'(inst), 64'(exp_inst));
      check({tag, "_ipc"},    inst_pc, exp_pc);
      check({tag, "_ierr"},   64'(inst_err), 64'(exp_err));
   endtask

   task automatic accept();
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
      tick(); tick(); tick();

      // Reset state
      check("rst_arvalid",  64'(arvalid),    64'd0);
      check("rst_rready",   64'(rready),     64'd0);
      check("rst_ivalid",   64'(inst_valid), 64'd0);
      check("rst_ierr",     64'(inst_err),   64'd0);
      check("rst_inst",     64'(inst),       64'd0);
      check("rst_ipc",      inst_pc,         64'd0);
      check("rst_cnt",      fetch_cnt,       64'd0);
      rst = 1'b0;
      check("idle_arvalid", 64'(arvalid),    64'd0);
      tick();
      check("first_arvalid", 64'(arvalid),   64'd1);

      // Two back-to-back fetches from one beat
      fetch("f1", 64'h8000_0000, 64'h00000013_00100093, 2'b00, 32'h0010_0093, 64'h8000_0000, 1'b0);
      accept();
      check("f1_next_ar", 64'(arvalid), 64'd1);
      fetch("f2", 64'h8000_0004, 64'h00000013_00100093, 2'b00, 32'h0000_0013, 64'h8000_0004, 1'b0);
      accept();
      check("cnt_2", fetch_cnt, 64'd2);

      // Redirect while arready is held low; the response is dropped
      arready = 1'b0;
      check("ar_hold1", 64'(araddr), 64'h8000_0008);
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_1000;
      check("ar_hold2", 64'(araddr), 64'h8000_0008);
      tick();
      redirect_valid = 1'b0;
      check("ar_hold3", 64'(araddr), 64'h8000_0008);
      check("ar_hold3_v", 64'(arvalid), 64'd1);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      check("kill_r_addr", 64'(araddr), 64'h8000_0008);
      rvalid = 1'b1;
      rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      rvalid = 1'b0;
      check("kill_ivalid", 64'(inst_valid), 64'd0);
      check("kill_arvalid", 64'(arvalid), 64'd1);
      check("kill_araddr", 64'(araddr), 64'h8000_1000);
      fetch("f3", 64'h8000_1000, 64'hDEADBEEF_CAFEF00D, 2'b00, 32'hCAFE_F00D, 64'h8000_1000, 1'b0);
      accept();
      check("cnt_3", fetch_cnt, 64'd3);

      // Decode back-pressure for five cycles
      fetch("f4", 64'h8000_1004, 64'h11112222_33334444, 2'b00, 32'h1111_2222, 64'h8000_1004, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_ivalid",  64'(inst_valid), 64'd1);
         check("stall_inst",    64'(inst),       64'h1111_2222);
         check("stall_ipc",     inst_pc,         64'h8000_1004);
         check("stall_arvalid", 64'(arvalid),    64'd0);
      end
      accept();
      check("cnt_4", fetch_cnt, 64'd4);

      // Redirect coinciding with decode accept
      fetch("f5", 64'h8000_1008, 64'h55556666_77778888, 2'b00, 32'h7777_8888, 64'h8000_1008, 1'b0);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0203;
      inst_ready     = 1'b1;
      tick();
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
      check("redir_ivalid",  64'(inst_valid), 64'd0);
      check("redir_cnt",     fetch_cnt,       64'd5);
      check("redir_arvalid", 64'(arvalid),    64'd1);
      check("redir_araddr",  64'(araddr),     64'h8000_0200);

      // Error response then OKAY at pc+4
      fetch("ferr", 64'h8000_0200, 64'hAAAA0000_BBBB0000, 2'b10, 32'hBBBB_0000, 64'h8000_0200, 1'b1);
      accept();
      fetch("fok", 64'h8000_0204, 64'hCCCC1111_DDDD2222, 2'b00, 32'hCCCC_1111, 64'h8000_0204, 1'b0);
      accept();
      check("cnt_7", fetch_cnt, 64'd7);

      // Reset in R with rvalid in the same cycle
      wait_arvalid("pre_rst_arvalid");
      arready = 1'b1;
      tick();
      arready = 1'b0;
      check("pre_rst_rready", 64'(rready), 64'd1);
      rst    = 1'b1;
      rvalid = 1'b1;
      rdata  = 64'h1234_5678_9ABC_DEF0;
      tick();
      rst    = 1'b0;
      rvalid = 1'b0;
      check("mrst_ivalid",  64'(inst_valid), 64'd0);
      check("mrst_arvalid", 64'(arvalid),    64'd0);
      check("mrst_rready",  64'(rready),     64'd0);
      check("mrst_cnt",     fetch_cnt,       64'd0);
      check("mrst_ipc",     inst_pc,         64'd0);
      tick();
      check("mrst_ar",      64'(arvalid),    64'd1);
      check("mrst_araddr",  64'(araddr),     64'h8000_0000);
      check("mrst_ivalid2", 64'(inst_valid), 64'd0);
      fetch("f8", 64'h8000_0000, 64'h00000013_00100093, 2'b00, 32'h0010_0093, 64'h8000_0000, 1'b0);
      accept();
      check("cnt_final", fetch_cnt, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
